alu_control_unit: RTL

- Hardwired microsequencer that drives the phase-1 CPU datapath control lines for fetch and register-register ALU execution. It replaces the hand-driven T0–T5 stimulus used in the per-op datapath benches.
- Instruction decode: it reads the IR from the datapath, decodes opcode and register fields, and steps through the T-states.
- Memory handshake: it holds in the fetch read state until memory signals ready.
- Stops: it handles HI/LO writeback for mul/div, and halt/stop.

---
 rtl/cpu_defs_pkg.sv | 39 +++
 rtl/cu_opcode_decode.sv | 34 +++
 rtl/alu_control_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the phase-1 CPU control unit:
// opcodes, sequencer state encoding and IR field positions.
package cpu_defs_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode classifier for the control unit.
// Unlisted opcodes decode to all-zero and behave as nop.
module cu_opcode_decode
    import cpu_defs_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opc,
    output logic             is_alu,
    output logic             is_muldiv,
    output logic             is_halt,
    output logic             is_nop
);

    always_comb begin
        is_alu    = 1'b0;
        is_muldiv = 1'b0;
        is_halt   = 1'b0;
        is_nop    = 1'b0;
        unique case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL: is_alu = 1'b1;
            OP_MUL, OP_DIV: begin
                is_alu    = 1'b1;
                is_muldiv = 1'b1;
            end
            OP_NOP:  is_nop  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// Hardwired T-state microsequencer: instruction fetch plus
// register-register ALU execute, with HI/LO writeback and halt.
module alu_control_unit
    import cpu_defs_pkg::*;
#(
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [31:0]      IR,
    input  logic             Mem_ready,
    input  logic             Stop,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [OPC_W-1:0] ALU_op,
    output logic             Run
);

    localparam int CNT_W =
        (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] dec_opc;
    logic             is_alu;
    logic             is_muldiv;
    logic             is_halt;
    logic             is_nop;
    logic             t1_done;
    state_t           end_state;
    logic             unused_bits;

    // IR is live in T3; afterwards the latched copy drives decode
    assign dec_opc = (state == S_T3) ? IR[OPC_MSB -: OPC_W] : opc_q;

    cu_opcode_decode #(
        .OPC_W(OPC_W)
    ) u_dec (
        .opc      (dec_opc),
        .is_alu   (is_alu),
        .is_muldiv(is_muldiv),
        .is_halt  (is_halt),
        .is_nop   (is_nop)
    );

    assign t1_done = Mem_ready ||
        ((MEM_TIMEOUT > 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT)));

    assign end_state = Stop ? S_HALT : S_T0;

    assign unused_bits = ^{IR[RA_MSB:RA_LSB], IR[RB_MSB:RB_LSB],
                           IR[RC_MSB:RC_LSB], IR[RC_LSB-1:0], is_nop};

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= S_RESET;
            wait_cnt <= '0;
            opc_q    <= '0;
        end else begin
            unique case (state)
                S_RESET: state <= S_T0;
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= '0;
                end
                S_T1: begin
                    if (t1_done) begin
                        state    <= S_T2;
                        wait_cnt <= '0;
                    end else if (MEM_TIMEOUT > 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    opc_q <= IR[OPC_MSB -: OPC_W];
                    if (is_halt)
                        state <= S_HALT;
                    else if (is_alu)
                        state <= S_T4;
                    else
                        state <= end_state;
                end
                S_T4: state <= S_T5;
                S_T5: state <= is_muldiv ? S_T6 : end_state;
                S_T6: state <= end_state;
                S_HALT: state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        ALU_op   = '0;
        Run      = 1'b0;
        unique case (state)
            S_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = t1_done;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run  = 1'b1;
                Grb  = is_alu;
                Rout = is_alu;
                Yin  = is_alu;
            end
            S_T4: begin
                Run    = 1'b1;
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zin    = 1'b1;
                ALU_op = opc_q;
            end
            S_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                LOin    = is_muldiv;
                Gra     = !is_muldiv;
                Rin     = !is_muldiv;
            end
            S_T6: begin
                Run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
